vend_txn_controller: RTL and testbench
======================================

Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine.
- Edge-detects the coin and buy inputs, owns the 12-bit credit register and validates each purchase against price and stock.
- Drives a req/ack handshake to the product dispenser/stock datapath, then returns change as timed 100c/25c coin pulses.
- Sits between the front-panel inputs and the stock/dispense datapath; it is the only writer of credit.

Parameters:
- PRICE0, 25, cost of product 0 in cents (must be a multiple of 25)
- PRICE1, 75, cost of product 1
- PRICE2, 150, cost of product 2
- PRICE3, 200, cost of product 3
- MAX_CREDIT, 1000, credit ceiling in cents; coins that would exceed it are rejected
- ACK_TIMEOUT, 64, cycles to wait for vend_ack before aborting a vend
- IDLE_TIMEOUT, 4096, idle cycles with credit>0 before auto-refund
- CHANGE_GAP, 4, cycles between successive change pulses (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- coin1  in  1  25c coin sensor, level; rising edge = coin inserted
- coin2  in  1  100c coin sensor, level; rising edge = coin inserted
- select  in  4  one-hot product select, sampled on buy edge
- buy  in  1  buy button, level; rising edge = purchase request
- refund  in  1  refund button, level; rising edge = return credit
- stock_empty  in  4  per-product out-of-stock flags from the stock datapath
- vend_ack  in  1  dispenser accepted the vend (single-cycle pulse)
- vend_req  out  1  vend request, held high until ack or timeout
- vend_sel  out  4  one-hot product being vended; valid while vend_req=1
- change25  out  1  one-cycle pulse, eject one 25c coin
- change100  out  1  one-cycle pulse, eject one 100c coin
- credit  out  12  current credit in cents
- coin_reject  out  1  one-cycle pulse, inserted coin refused (return chute)
- err_funds  out  1  one-cycle pulse, buy refused because credit < price
- err_stock  out  1  one-cycle pulse, buy refused because product is empty
- err_select  out  1  one-cycle pulse, buy refused because select is not one-hot
- fault  out  1  one-cycle pulse, vend_ack timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset: state=IDLE, credit=0, all outputs 0, timers 0. Edge-detect history registers load 1, so inputs held high through reset do not fire.
- Edge detection: history registers are updated every cycle. All decisions in a cycle use that cycle's edges (1-cycle response latency).
- States: IDLE, VEND_WAIT, CHANGE.

IDLE:
- Coins: a coin1 edge adds 25 if credit+25<=MAX_CREDIT, else coin_reject. A coin2 edge is then evaluated against the updated credit: +100 or coin_reject. Both edges in one cycle are legal.
- Buy: a buy edge in the same cycle as a coin edge is evaluated after the coin adds.
- Buy check order: first select not one-hot -> err_select. Next, credit<price -> err_funds. Next, stock_empty[i] -> err_stock. Otherwise credit-=price, vend_sel=select, vend_req=1, go to VEND_WAIT.
- Refund: a refund edge with credit>0 goes to CHANGE; with credit=0 it is ignored. Buy has priority over a simultaneous refund.
- Idle timer: counts while credit>0 and resets on any coin/buy/refund edge. At IDLE_TIMEOUT it goes to CHANGE.

VEND_WAIT:
- vend_ack: drop vend_req and vend_sel. If credit>0 go to CHANGE, else IDLE.
- ACK_TIMEOUT cycles without ack: credit+=price (restore), drop vend_req, pulse fault, go to IDLE.
- Coin edges here -> coin_reject, credit unchanged. Buy and refund are ignored.

CHANGE:
- Emits change100 while credit>=100, else change25 while credit>=25. Each pulse subtracts its value in the same cycle.
- The first pulse fires one cycle after entry. Pulses are spaced CHANGE_GAP cycles apart.
- At credit=0 go to IDLE. Coin edges here -> coin_reject. Buy and refund are ignored.

Arithmetic and invariants:
- credit is always a multiple of 25 and never exceeds MAX_CREDIT or goes below 0.
- Subtraction occurs only after the >= check.
- Error, coin_reject and fault pulses are exactly one cycle.
- rst mid-operation aborts immediately to reset values; no change is owed after reset.

Decomposition:
- Package vend_pkg holds: state enum (IDLE, VEND_WAIT, CHANGE), coin value constants (COIN_25=25, COIN_100=100), credit width (12), and the product count (4).
- One sub-module, vend_edge_detect: a 4-bit rising-edge detector with reset-to-1 history.
- Price lookup, credit and FSM stay in the top module.

Test Plan:
- coin1 edge x3, select=0010, buy -> credit 75 then 0; vend_req=1, vend_sel=0010 until ack; no change pulses; back to IDLE.
- coin2 x2, select=0001, buy, ack -> credit 175. CHANGE emits change100 once, then change25 x3, CHANGE_GAP=4 cycles apart. credit=0, busy=0.
- coin2 once, select=0100 -> err_funds pulse, credit stays 100. Then select=0110 -> err_select. Then stock_empty=1000, select=1000 with credit 200 -> err_stock.
- credit=975 via coins, then coin1 and coin2 in the same cycle -> credit 1000 and one coin_reject pulse.
- Buy accepted, vend_ack never arrives -> after 64 cycles: fault pulse, credit restored to original value, vend_req=0, state IDLE.
- credit=50, rst asserted while in VEND_WAIT -> next cycle credit=0, all outputs 0. Buy held high through reset produces no buy edge.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VEND_WAIT = 2'd1,
    CHANGE    = 2'd2
  } vend_state_t;

  localparam int CREDIT_W = 12;
  localparam int N_PROD   = 4;
  localparam int COIN_25  = 25;
  localparam int COIN_100 = 100;

endpackage

// File: rtl/vend_edge_detect.sv
// Rising-edge detector; history resets to 1 so levels held through reset never fire.
module vend_edge_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  output logic [3:0] rise
);

  logic [3:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin/buy handling, credit ownership, vend handshake, change return.
// state     | meaning
// IDLE      | accept coins, buy and refund; idle timer runs while credit > 0
// VEND_WAIT | vend_req held, waiting for vend_ack or timeout
// CHANGE    | paying out credit as spaced 100c/25c pulses
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int PRICE0       = 25,
  parameter int PRICE1       = 75,
  parameter int PRICE2       = 150,
  parameter int PRICE3       = 200,
  parameter int MAX_CREDIT   = 1000,
  parameter int ACK_TIMEOUT  = 64,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int CHANGE_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin1,
  input  logic                coin2,
  input  logic [N_PROD-1:0]   select,
  input  logic                buy,
  input  logic                refund,
  input  logic [N_PROD-1:0]   stock_empty,
  input  logic                vend_ack,
  output logic                vend_req,
  output logic [N_PROD-1:0]   vend_sel,
  output logic                change25,
  output logic                change100,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_stock,
  output logic                err_select,
  output logic                fault,
  output logic                busy
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int GW = $clog2(CHANGE_GAP + 1);
  localparam logic [AW-1:0]       ACK_LOAD  = AW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0]       IDLE_LOAD = IW'(IDLE_TIMEOUT - 1);
  localparam logic [GW-1:0]       GAP_LOAD  = GW'(CHANGE_GAP - 1);
  localparam logic [CREDIT_W-1:0] C25       = CREDIT_W'(COIN_25);
  localparam logic [CREDIT_W-1:0] C100      = CREDIT_W'(COIN_100);
  localparam logic [CREDIT_W-1:0] LIM25     = CREDIT_W'(MAX_CREDIT - COIN_25);
  localparam logic [CREDIT_W-1:0] LIM100    = CREDIT_W'(MAX_CREDIT - COIN_100);

  vend_state_t         state, state_nxt;
  logic [CREDIT_W-1:0] credit_r, credit_nxt, credit_coin, vend_price, price_nxt, price;
  logic [N_PROD-1:0]   sel_r, sel_nxt;
  logic [AW-1:0]       ack_cnt, ack_cnt_nxt;
  logic [IW-1:0]       idle_cnt, idle_cnt_nxt;
  logic [GW-1:0]       gap_cnt, gap_cnt_nxt;
  logic [3:0]          rise;
  logic                any_edge, sel_onehot;
  logic                rej_r, funds_r, stock_r, selerr_r, fault_r, c25_r, c100_r;
  logic                rej_nxt, funds_nxt, stock_nxt, selerr_nxt, fault_nxt, c25_nxt, c100_nxt;

  vend_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({refund, buy, coin2, coin1}),
    .rise (rise)
  );

  assign any_edge   = |rise;
  assign sel_onehot = (select != '0) && ((select & (select - 1'b1)) == '0);

  always_comb begin
    price = '0;
    case (select)
      4'b0001: price = CREDIT_W'(PRICE0);
      4'b0010: price = CREDIT_W'(PRICE1);
      4'b0100: price = CREDIT_W'(PRICE2);
      4'b1000: price = CREDIT_W'(PRICE3);
      default: price = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      credit_r   <= '0;
      vend_price <= '0;
      sel_r      <= '0;
      ack_cnt    <= '0;
      idle_cnt   <= '0;
      gap_cnt    <= '0;
      rej_r      <= 1'b0;
      funds_r    <= 1'b0;
      stock_r    <= 1'b0;
      selerr_r   <= 1'b0;
      fault_r    <= 1'b0;
      c25_r      <= 1'b0;
      c100_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit_r   <= credit_nxt;
      vend_price <= price_nxt;
      sel_r      <= sel_nxt;
      ack_cnt    <= ack_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      rej_r      <= rej_nxt;
      funds_r    <= funds_nxt;
      stock_r    <= stock_nxt;
      selerr_r   <= selerr_nxt;
      fault_r    <= fault_nxt;
      c25_r      <= c25_nxt;
      c100_r     <= c100_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit_r;
    credit_coin  = credit_r;
    price_nxt    = vend_price;
    sel_nxt      = sel_r;
    ack_cnt_nxt  = ack_cnt;
    idle_cnt_nxt = IDLE_LOAD;
    gap_cnt_nxt  = gap_cnt;
    rej_nxt      = 1'b0;
    funds_nxt    = 1'b0;
    stock_nxt    = 1'b0;
    selerr_nxt   = 1'b0;
    fault_nxt    = 1'b0;
    c25_nxt      = 1'b0;
    c100_nxt     = 1'b0;
    case (state)
      IDLE: begin
        // coin2 is judged against credit already including a same-cycle coin1
        if (rise[0]) begin
          if (credit_coin <= LIM25) credit_coin = credit_coin + C25;
          else                      rej_nxt = 1'b1;
        end
        if (rise[1]) begin
          if (credit_coin <= LIM100) credit_coin = credit_coin + C100;
          else                       rej_nxt = 1'b1;
        end
        credit_nxt = credit_coin;
        if (rise[2]) begin
          if (!sel_onehot)                   selerr_nxt = 1'b1;
          else if (credit_coin < price)      funds_nxt  = 1'b1;
          else if ((stock_empty & select) != '0) stock_nxt = 1'b1;
          else begin
            credit_nxt  = credit_coin - price;
            price_nxt   = price;
            sel_nxt     = select;
            ack_cnt_nxt = ACK_LOAD;
            state_nxt   = VEND_WAIT;
          end
        end else if (rise[3] && credit_coin != '0) begin
          gap_cnt_nxt = '0;
          state_nxt   = CHANGE;
        end else if (!any_edge && credit_r != '0) begin
          if (idle_cnt == '0) begin
            gap_cnt_nxt = '0;
            state_nxt   = CHANGE;
          end else begin
            idle_cnt_nxt = idle_cnt - 1'b1;
          end
        end
      end
      VEND_WAIT: begin
        rej_nxt = rise[0] | rise[1];
        if (vend_ack) begin
          sel_nxt     = '0;
          gap_cnt_nxt = '0;
          state_nxt   = (credit_r != '0) ? CHANGE : IDLE;
        end else if (ack_cnt == '0) begin
          credit_nxt = credit_r + vend_price;
          sel_nxt    = '0;
          fault_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt - 1'b1;
        end
      end
      CHANGE: begin
        rej_nxt = rise[0] | rise[1];
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end else if (credit_r >= C100) begin
          c100_nxt    = 1'b1;
          credit_nxt  = credit_r - C100;
          gap_cnt_nxt = GAP_LOAD;
        end else if (credit_r >= C25) begin
          c25_nxt     = 1'b1;
          credit_nxt  = credit_r - C25;
          gap_cnt_nxt = GAP_LOAD;
        end
        if (credit_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vend_req    = (state == VEND_WAIT);
    vend_sel    = vend_req ? sel_r : '0;
    busy        = (state != IDLE);
    credit      = credit_r;
    coin_reject = rej_r;
    err_funds   = funds_r;
    err_stock   = stock_r;
    err_select  = selerr_r;
    fault       = fault_r;
    change25    = c25_r;
    change100   = c100_r;
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed scoreboard bench for vend_txn_controller.
module tb_vend_txn_controller;

  logic        clk = 1'b0;
  logic        rst, coin1, coin2, buy, refund, vend_ack;
  logic [3:0]  select, stock_empty;
  logic        vend_req, change25, change100, coin_reject;
  logic        err_funds, err_stock, err_select, fault, busy;
  logic [3:0]  vend_sel;
  logic [11:0] credit;

  always #5 clk = ~clk;

  vend_txn_controller dut (
    .clk (clk), .rst (rst), .coin1 (coin1), .coin2 (coin2), .select (select),
    .buy (buy), .refund (refund), .stock_empty (stock_empty), .vend_ack (vend_ack),
    .vend_req (vend_req), .vend_sel (vend_sel), .change25 (change25),
    .change100 (change100), .credit (credit), .coin_reject (coin_reject),
    .err_funds (err_funds), .err_stock (err_stock), .err_select (err_select),
    .fault (fault), .busy (busy)
  );

  typedef struct { string tag; int val; } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int cnt_c25 = 0, cnt_c100 = 0, cnt_rej = 0, cnt_funds = 0, cnt_stock = 0;
  int cnt_sel = 0, cnt_fault = 0, req_cycles = 0;
  int pulse_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (change25)    cnt_c25++;
      if (change100)   cnt_c100++;
      if (coin_reject) cnt_rej++;
      if (err_funds)   cnt_funds++;
      if (err_stock)   cnt_stock++;
      if (err_select)  cnt_sel++;
      if (fault)       cnt_fault++;
      if (vend_req)    req_cycles++;
      if (change25 || change100) pulse_cyc.push_back(cyc);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic expect_v(string tag, int v);
    exp_t e;
    e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === 32'(e.val)) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic coin25();  coin1 = 1'b1; step(); coin1 = 1'b0; step(); endtask
  task automatic coin100(); coin2 = 1'b1; step(); coin2 = 1'b0; step(); endtask
  task automatic press_buy(logic [3:0] s);
    select = s; buy = 1'b1; step(); buy = 1'b0; step();
  endtask
  task automatic press_refund(); refund = 1'b1; step(); refund = 1'b0; step(); endtask
  task automatic do_ack(); vend_ack = 1'b1; step(); vend_ack = 1'b0; step(); endtask

  task automatic wait_idle(string tag, int budget);
    int i = 0;
    while (busy && i < budget) begin step(); i++; end
    expect_v(tag, 1);
    check(32'(i < budget));
  endtask

  int b25, b100, b_rej, b_funds, b_sel, b_stock, b_fault, b_req;

  initial begin
    rst = 1'b1; coin1 = 0; coin2 = 0; buy = 0; refund = 0; vend_ack = 0;
    select = '0; stock_empty = '0;
    step(3);
    expect_v("rst_credit", 0);   check(32'(credit));
    expect_v("rst_vend_req", 0); check(32'(vend_req));
    expect_v("rst_busy", 0);     check(32'(busy));
    expect_v("rst_pulses", 0);
    check(32'({change25, change100, coin_reject, err_funds, err_stock, err_select, fault}));
    rst = 1'b0;
    step();

    // three quarters then buy product 1 with exact credit
    b25 = cnt_c25; b100 = cnt_c100;
    repeat (3) coin25();
    expect_v("t1_credit75", 75); check(32'(credit));
    press_buy(4'b0010);
    expect_v("t1_credit0", 0);   check(32'(credit));
    expect_v("t1_req", 1);       check(32'(vend_req));
    expect_v("t1_sel", 2);       check(32'(vend_sel));
    step(5);
    expect_v("t1_req_held", 1);  check(32'(vend_req));
    do_ack();
    expect_v("t1_req_drop", 0);  check(32'(vend_req));
    expect_v("t1_sel_drop", 0);  check(32'(vend_sel));
    expect_v("t1_busy", 0);      check(32'(busy));
    expect_v("t1_no_change", 0); check(32'((cnt_c25 - b25) + (cnt_c100 - b100)));

    // overpay then change 100 + 3x25 spaced by the gap
    b25 = cnt_c25; b100 = cnt_c100; pulse_cyc.delete();
    coin100(); coin100();
    expect_v("t2_credit200", 200); check(32'(credit));
    press_buy(4'b0001);
    expect_v("t2_credit175", 175); check(32'(credit));
    do_ack();
    wait_idle("t2_change_done", 100);
    expect_v("t2_c100", 1);        check(32'(cnt_c100 - b100));
    expect_v("t2_c25", 3);         check(32'(cnt_c25 - b25));
    expect_v("t2_credit0", 0);     check(32'(credit));
    expect_v("t2_npulses", 4);     check(32'(pulse_cyc.size()));
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      expect_v("t2_gap", 4);
      check(32'(pulse_cyc[i] - pulse_cyc[i-1]));
    end

    // refused buys: funds, select, stock
    b_funds = cnt_funds; b_sel = cnt_sel; b_stock = cnt_stock; b100 = cnt_c100;
    coin100();
    press_buy(4'b0100);
    expect_v("t3_funds", 1);       check(32'(cnt_funds - b_funds));
    expect_v("t3_credit100", 100); check(32'(credit));
    press_buy(4'b0110);
    expect_v("t3_select", 1);      check(32'(cnt_sel - b_sel));
    coin100();
    stock_empty = 4'b1000;
    press_buy(4'b1000);
    expect_v("t3_stock", 1);       check(32'(cnt_stock - b_stock));
    expect_v("t3_credit200", 200); check(32'(credit));
    expect_v("t3_busy", 0);        check(32'(busy));
    stock_empty = '0;
    press_refund();
    wait_idle("t3_refund_done", 100);
    expect_v("t3_refund_c100", 2); check(32'(cnt_c100 - b100));
    expect_v("t3_credit0", 0);     check(32'(credit));

    // credit ceiling with simultaneous coins
    b_rej = cnt_rej;
    repeat (9) coin100();
    repeat (3) coin25();
    expect_v("t4_credit975", 975); check(32'(credit));
    coin1 = 1'b1; coin2 = 1'b1; step(); coin1 = 1'b0; coin2 = 1'b0; step();
    expect_v("t4_credit1000", 1000); check(32'(credit));
    expect_v("t4_reject", 1);        check(32'(cnt_rej - b_rej));
    coin25();
    expect_v("t4_reject25", 2);      check(32'(cnt_rej - b_rej));
    expect_v("t4_credit_cap", 1000); check(32'(credit));
    press_refund();
    wait_idle("t4_refund_done", 300);
    expect_v("t4_credit0", 0);       check(32'(credit));

    // ack timeout restores credit
    b_fault = cnt_fault;
    coin100(); coin100();
    press_buy(4'b0100);
    b_req = req_cycles - 2;
    expect_v("t5_credit50", 50); check(32'(credit));
    begin
      int i = 0;
      while (cnt_fault == b_fault && i < 100) begin step(); i++; end
      expect_v("t5_fault_seen", 1); check(32'(i < 100));
    end
    step(2);
    expect_v("t5_fault_once", 1);  check(32'(cnt_fault - b_fault));
    expect_v("t5_req_cycles", 64); check(32'(req_cycles - b_req));
    expect_v("t5_credit200", 200); check(32'(credit));
    expect_v("t5_req", 0);         check(32'(vend_req));
    expect_v("t5_busy", 0);        check(32'(busy));
    press_refund();
    wait_idle("t5_refund_done", 100);

    // reset during VEND_WAIT, buy held through reset
    repeat (3) coin25();
    press_buy(4'b0001);
    expect_v("t6_credit50", 50); check(32'(credit));
    expect_v("t6_busy", 1);      check(32'(busy));
    select = 4'b0001; buy = 1'b1; rst = 1'b1;
    step();
    expect_v("t6_rst_credit", 0); check(32'(credit));
    expect_v("t6_rst_req", 0);    check(32'(vend_req));
    expect_v("t6_rst_sel", 0);    check(32'(vend_sel));
    expect_v("t6_rst_busy", 0);   check(32'(busy));
    expect_v("t6_rst_pulses", 0);
    check(32'({change25, change100, coin_reject, err_funds, err_stock, err_select, fault}));
    rst = 1'b0;
    b_funds = cnt_funds;
    step(3);
    expect_v("t6_no_buy_edge", 0); check(32'(cnt_funds - b_funds));
    expect_v("t6_idle", 0);        check(32'(busy));
    buy = 1'b0;
    step();

    // idle timeout auto-refund
    b25 = cnt_c25;
    coin25();
    step(4000);
    expect_v("t7_not_yet", 0);    check(32'(busy));
    expect_v("t7_credit25", 25);  check(32'(credit));
    begin
      int i = 0;
      while (!busy && cnt_c25 == b25 && i < 200) begin step(); i++; end
      expect_v("t7_timeout_fired", 1); check(32'(i < 200));
    end
    wait_idle("t7_refund_done", 100);
    expect_v("t7_c25", 1);       check(32'(cnt_c25 - b25));
    expect_v("t7_credit0", 0);   check(32'(credit));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
